d_p_ram_init: RTL and testbench

D_P_RAM_INIT -- requirements
Module: d_p_ram_init

---
 rtl/d_p_ram_pkg.sv | 22 ++
 rtl/d_p_ram.sv | 50 +++++
 rtl/d_p_ram_init.sv | 245 ++++++++++++++++++++++++
 tb/tb_d_p_ram_init.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/d_p_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : d_p_ram_pkg
// Description : Shared types and constants for the initialising dual-port RAM.
//               Holds the controller state encoding and the collision-mode
//               selector values.
// Revision    : 1.0 - initial release
// ============================================================================
package d_p_ram_pkg;

    // Controller states: INIT sweeps INIT_VALUE through memory, RUN serves users.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Behaviour of a read that hits the word written in the same cycle.
    localparam int CM_READ_OLD      = 0;
    localparam int CM_WRITE_THROUGH = 1;

endpackage : d_p_ram_pkg
`default_nettype wire

// File: rtl/d_p_ram.sv
`default_nettype none
// ============================================================================
// Module      : d_p_ram
// Description : Simple dual-port RAM, one write port and one registered read
//               port on a single clock. Read-before-write on a same-address
//               collision. No reset on storage or read register so that the
//               array maps onto block RAM.
// Ports       : clock        - rising-edge clock
//               write_en     - write strobe
//               write_addr   - write word address (must be < DEPTH)
//               input_data   - write data
//               read_en      - read strobe; read register holds when low
//               read_addr    - read word address (must be < DEPTH)
//               output_data  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module d_p_ram #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = (1 << ADDR_WIDTH)
) (
    input  logic                  clock,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] output_data
);

    // Index only as many address bits as the array needs.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [0:(1 << IDX_W)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read and write in one process: the read sees the pre-write contents.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_addr[IDX_W-1:0]] <= input_data;
        end
        if (read_en) begin
            rdata_q <= mem[read_addr[IDX_W-1:0]];
        end
    end

    assign output_data = rdata_q;

endmodule : d_p_ram
`default_nettype wire

// File: rtl/d_p_ram_init.sv
`default_nettype none
// ============================================================================
// Module      : d_p_ram_init
// Description : Byte-lane dual-port RAM that sweeps INIT_VALUE through every
//               word after reset before accepting user traffic. Reads are
//               fully pipelined with 1 or 2 cycles of latency; same-address
//               read/write collisions return old data or write-through data.
// Ports       : clock        - rising-edge clock
//               reset_n      - synchronous active-low reset
//               ready        - initialisation finished, user accesses accepted
//               write_en     - write request
//               write_addr   - write word address
//               write_be     - per-lane write enables
//               input_data   - write data
//               read_en      - read request
//               read_addr    - read word address
//               output_data  - read data, held between valid pulses
//               output_valid - one-cycle pulse per completed read
// Revision    : 1.0 - initial release
// ============================================================================
module d_p_ram_init
    import d_p_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 3,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    DEPTH          = (1 << ADDR_WIDTH),
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    COLLISION_MODE = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic                             clock,
    input  logic                             reset_n,
    output logic                             ready,
    input  logic                             write_en,
    input  logic [ADDR_WIDTH-1:0]            write_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] write_be,
    input  logic [DATA_WIDTH-1:0]            input_data,
    input  logic                             read_en,
    input  logic [ADDR_WIDTH-1:0]            read_addr,
    output logic [DATA_WIDTH-1:0]            output_data,
    output logic                             output_valid
);

    localparam int                    NB        = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] INIT_LAST = ADDR_WIDTH'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic                    ready_q, ready_d;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                if (init_cnt_q == INIT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
        // Registered copy of the next state so ready tracks state exactly.
        ready_d = (state_d == RUN);
    end

    // ------------------------------------------------------------------
    // Write port: INIT sweep or user write, user writes out of range dropped
    // ------------------------------------------------------------------
    logic                  w_wr_in_range;
    logic                  w_user_wr;
    logic [NB-1:0]         w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_waddr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;

    always_comb begin
        w_wr_in_range = ({1'b0, write_addr} < DEPTH_EXT);
        w_user_wr     = ready_q & write_en & w_wr_in_range;
        w_ram_waddr   = write_addr;
        w_ram_wdata   = input_data;
        w_ram_we      = '0;
        if (state_q == INIT) begin
            w_ram_waddr = init_cnt_q;
            w_ram_wdata = INIT_VALUE;
        end
        for (int i = 0; i < NB; i++) begin
            // Gate with reset_n: reset alone never modifies memory.
            w_ram_we[i] = reset_n & ((state_q == INIT) | (w_user_wr & write_be[i]));
        end
    end

    // ------------------------------------------------------------------
    // Read acceptance and collision detection
    // ------------------------------------------------------------------
    logic w_rd_acc;
    logic w_rd_in_range;
    logic w_ram_re;
    logic w_coll;

    always_comb begin
        w_rd_acc      = ready_q & read_en;
        w_rd_in_range = ({1'b0, read_addr} < DEPTH_EXT);
        w_ram_re      = w_rd_acc & w_rd_in_range;
        w_coll        = w_ram_re & w_user_wr & (write_addr == read_addr);
    end

    // ------------------------------------------------------------------
    // Storage: one byte-wide RAM per lane
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    generate
        for (genvar g = 0; g < NB; g++) begin : g_lane
            d_p_ram #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .DATA_WIDTH (BYTE_WIDTH),
                .DEPTH      (DEPTH)
            ) u_ram (
                .clock       (clock),
                .write_en    (w_ram_we[g]),
                .write_addr  (w_ram_waddr),
                .input_data  (w_ram_wdata[g*BYTE_WIDTH +: BYTE_WIDTH]),
                .read_en     (w_ram_re),
                .read_addr   (read_addr),
                .output_data (w_ram_rdata[g*BYTE_WIDTH +: BYTE_WIDTH])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // First read stage: side information captured alongside the RAM read.
    // Everything holds between accepted reads so the stage output is stable.
    // ------------------------------------------------------------------
    logic                  rd1_v_q,     rd1_v_d;
    logic                  rd1_has_q,   rd1_has_d;
    logic                  rd1_oob_q,   rd1_oob_d;
    logic                  rd1_coll_q,  rd1_coll_d;
    logic [DATA_WIDTH-1:0] rd1_wdata_q, rd1_wdata_d;
    logic [NB-1:0]         rd1_wbe_q,   rd1_wbe_d;
    logic [DATA_WIDTH-1:0] w_rd1_data;

    always_comb begin
        rd1_v_d     = w_rd_acc;
        rd1_has_d   = rd1_has_q | w_rd_acc;
        rd1_oob_d   = rd1_oob_q;
        rd1_coll_d  = rd1_coll_q;
        rd1_wdata_d = rd1_wdata_q;
        rd1_wbe_d   = rd1_wbe_q;
        if (w_rd_acc) begin
            rd1_oob_d   = ~w_rd_in_range;
            rd1_coll_d  = w_coll;
            rd1_wdata_d = input_data;
            rd1_wbe_d   = write_be;
        end
    end

    // RAM delivers pre-write data; write-through patches the written lanes.
    // Until the first read after reset the stage reports zero.
    always_comb begin
        w_rd1_data = w_ram_rdata;
        if (!rd1_has_q) begin
            w_rd1_data = '0;
        end else if (rd1_oob_q) begin
            w_rd1_data = INIT_VALUE;
        end else if ((COLLISION_MODE == CM_WRITE_THROUGH) && rd1_coll_q) begin
            for (int i = 0; i < NB; i++) begin
                if (rd1_wbe_q[i]) begin
                    w_rd1_data[i*BYTE_WIDTH +: BYTE_WIDTH] = rd1_wdata_q[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            ready_q     <= 1'b0;
            rd1_v_q     <= 1'b0;
            rd1_has_q   <= 1'b0;
            rd1_oob_q   <= 1'b0;
            rd1_coll_q  <= 1'b0;
            rd1_wdata_q <= '0;
            rd1_wbe_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            ready_q     <= ready_d;
            rd1_v_q     <= rd1_v_d;
            rd1_has_q   <= rd1_has_d;
            rd1_oob_q   <= rd1_oob_d;
            rd1_coll_q  <= rd1_coll_d;
            rd1_wdata_q <= rd1_wdata_d;
            rd1_wbe_q   <= rd1_wbe_d;
        end
    end

    assign ready = ready_q;

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  out_v_q,    out_v_d;
            logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

            always_comb begin
                out_v_d    = rd1_v_q;
                out_data_d = out_data_q;
                if (rd1_v_q) begin
                    out_data_d = w_rd1_data;
                end
            end

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    out_v_q    <= 1'b0;
                    out_data_q <= '0;
                end else begin
                    out_v_q    <= out_v_d;
                    out_data_q <= out_data_d;
                end
            end

            assign output_valid = out_v_q;
            assign output_data  = out_data_q;
        end else begin : g_lat1
            assign output_valid = rd1_v_q;
            assign output_data  = w_rd1_data;
        end
    endgenerate

endmodule : d_p_ram_init
`default_nettype wire

// File: tb/tb_d_p_ram_init.sv
`default_nettype none
// ============================================================================
// Module      : tb_d_p_ram_init
// Description : Scoreboard bench for d_p_ram_init. Two instances share one
//               stimulus stream: dut0 (3-bit address, latency 1, read-old,
//               INIT_VALUE 0) and dut1 (4-bit address, DEPTH 8, latency 2,
//               write-through, non-zero INIT_VALUE). Expected read results
//               are queued at issue time and popped by per-instance monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d_p_ram_init;

    localparam logic [31:0] INIT1 = 32'hC0DE_0F0F;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        write_en;
    logic [3:0]  write_addr;
    logic [3:0]  write_be;
    logic [31:0] input_data;
    logic        read_en;
    logic [3:0]  read_addr;

    logic        ready0, valid0, ready1, valid1;
    logic [31:0] data0, data1;

    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;
    exp_t q0[$];
    exp_t q1[$];

    // Contents expected at addresses 0..7 before the pipelined sweep.
    logic [31:0] t0 [8] = '{32'h0, 32'h0, 32'hDEADBEEF, 32'hAA22CC44,
                            32'h77, 32'h0, 32'h00001111, 32'hCAFEF00D};
    logic [31:0] t1 [8] = '{INIT1, INIT1, 32'hDEADBEEF, 32'hAA22CC44,
                            INIT1, INIT1, 32'hC0DE1111, 32'hCAFEF00D};

    d_p_ram_init #(
        .ADDR_WIDTH     (3)
    ) dut0 (
        .clock        (clock),
        .reset_n      (reset_n),
        .ready        (ready0),
        .write_en     (write_en),
        .write_addr   (write_addr[2:0]),
        .write_be     (write_be),
        .input_data   (input_data),
        .read_en      (read_en),
        .read_addr    (read_addr[2:0]),
        .output_data  (data0),
        .output_valid (valid0)
    );

    d_p_ram_init #(
        .ADDR_WIDTH     (4),
        .DEPTH          (8),
        .READ_LATENCY   (2),
        .COLLISION_MODE (1),
        .INIT_VALUE     (INIT1)
    ) dut1 (
        .clock        (clock),
        .reset_n      (reset_n),
        .ready        (ready1),
        .write_en     (write_en),
        .write_addr   (write_addr),
        .write_be     (write_be),
        .input_data   (input_data),
        .read_en      (read_en),
        .read_addr    (read_addr),
        .output_data  (data1),
        .output_valid (valid1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop an expectation on every valid pulse.
    always @(negedge clock) begin
        if (valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                check("dut0 spurious output_valid", {31'b0, valid0}, 32'h0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("dut0 read data", data0, e.data);
                check("dut0 read cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clock) begin
        if (valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut1 spurious output_valid", {31'b0, valid1}, 32'h0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1 read data", data1, e.data);
                check("dut1 read cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One cycle of stimulus; queues the expected read result per instance.
    task automatic op(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic re, input logic [3:0] ra,
                      input logic push0, input logic push1,
                      input logic [31:0] e0, input logic [31:0] e1);
        write_en   = we;
        write_addr = wa;
        input_data = wd;
        write_be   = be;
        read_en    = re;
        read_addr  = ra;
        if (re && push0) q0.push_back('{data: e0, cyc: cyc + 1});
        if (re && push1) q1.push_back('{data: e1, cyc: cyc + 2});
        tick();
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        op(1'b1, a, d, be, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1);
        op(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, a, 1'b1, 1'b1, e0, e1);
    endtask

    task automatic reset_state_checks();
        check("dut0 ready in reset", {31'b0, ready0}, 32'h0);
        check("dut1 ready in reset", {31'b0, ready1}, 32'h0);
        check("dut0 valid in reset", {31'b0, valid0}, 32'h0);
        check("dut1 valid in reset", {31'b0, valid1}, 32'h0);
        check("dut0 data in reset", data0, 32'h0);
        check("dut1 data in reset", data1, 32'h0);
    endtask

    // Eight cycles of ready low, then ready high. Keeps hammering writes and
    // reads at address 0 that must be ignored while initialising.
    task automatic init_window();
        write_en   = 1'b1;
        write_addr = 4'h0;
        input_data = 32'h12345678;
        write_be   = 4'hF;
        read_en    = 1'b1;
        read_addr  = 4'h0;
        for (int i = 0; i < 8; i++) begin
            check("dut0 ready during init", {31'b0, ready0}, 32'h0);
            check("dut1 ready during init", {31'b0, ready1}, 32'h0);
            tick();
        end
        write_en = 1'b0;
        read_en  = 1'b0;
        check("dut0 ready after init", {31'b0, ready0}, 32'h1);
        check("dut1 ready after init", {31'b0, ready1}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        write_en   = 1'b0;
        write_addr = 4'h0;
        write_be   = 4'h0;
        input_data = 32'h0;
        read_en    = 1'b0;
        read_addr  = 4'h0;
        tick();
        tick();
        reset_state_checks();

        reset_n = 1'b1;
        init_window();

        // Read after init.
        rd(4'd5, 32'h0, INIT1);

        // Byte-lane merge.
        wr(4'd3, 32'hAABBCCDD, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd(4'd3, 32'hAA22CC44, 32'hAA22CC44);

        // Full-word collision, then the settled value.
        op(1'b1, 4'd2, 32'hDEADBEEF, 4'b1111, 1'b1, 4'd2, 1'b1, 1'b1, 32'h0, 32'hDEADBEEF);
        rd(4'd2, 32'hDEADBEEF, 32'hDEADBEEF);

        // Partial-lane collision.
        op(1'b1, 4'd6, 32'h11111111, 4'b0011, 1'b1, 4'd6, 1'b1, 1'b1, 32'h0, 32'hC0DE1111);

        // Address 12: aliases to 4 on dut0, out of range on dut1.
        wr(4'd12, 32'h00000077, 4'b1111);
        rd(4'd12, 32'h77, INIT1);
        rd(4'd4, 32'h77, INIT1);

        // Zero byte enables leave the word untouched.
        wr(4'd5, 32'hFFFFFFFF, 4'b0000);
        rd(4'd5, 32'h0, INIT1);

        // A write one cycle after a read's acceptance must not leak into it.
        rd(4'd7, 32'h0, INIT1);
        wr(4'd7, 32'hCAFEF00D, 4'b1111);

        // Back-to-back reads 0..7.
        for (int i = 0; i < 8; i++) begin
            rd(4'(i), t0[i], t1[i]);
        end
        tick();
        tick();

        // Reset with a read in flight: dut0 completes it before the reset
        // edge, dut1 (two stages) must discard it.
        wr(4'd1, 32'h5, 4'b1111);
        op(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd1, 1'b1, 1'b0, 32'h5, 32'h0);
        reset_n = 1'b0;
        tick();
        reset_state_checks();
        reset_n = 1'b1;
        init_window();
        rd(4'd1, 32'h0, INIT1);

        for (int i = 0; i < 4; i++) tick();
        check("dut0 reads still pending", q0.size(), 32'h0);
        check("dut1 reads still pending", q1.size(), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_d_p_ram_init
`default_nettype wire
